// File: rtl/sar_sequencer.sv
// SAR conversion sequencer: paces conversion requests, averages 2^AVG_LOG2
// results and hands each average downstream over a valid/ready port.
module sar_sequencer #(
  parameter int unsigned RATE_DIV = 64,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned TIMEOUT  = 32
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  output logic       start_o,
  input  logic       rdy_i,
  input  logic [7:0] code_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       overrun_o,
  output logic       err_o
);

  localparam int unsigned TW = $clog2(RATE_DIV);
  localparam int unsigned AW = 8 + AVG_LOG2;
  localparam int unsigned SW = AVG_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, ARM, WAIT_RDY, ACCUM} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q;
  logic [AW-1:0] acc_q;
  logic [SW-1:0] smp_q;
  logic [7:0]    tout_q;
  logic          tick, accept, timeout, avg_fire, xfer;
  logic [7:0]    avg;

  assign tick = en_i && (tmr_q == TW'(RATE_DIV - 1));
  assign avg  = acc_q[AW-1:AVG_LOG2];
  assign xfer = valid_o && ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          tmr_q <= '0;
    else if (!en_i || tick) tmr_q <= '0;
    else                  tmr_q <= tmr_q + TW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start_o  = 1'b0;
    accept   = 1'b0;
    timeout  = 1'b0;
    avg_fire = 1'b0;
    if (!en_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          if (tick) begin
            start_o = 1'b1;
            state_d = WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          // A result arriving in the last allowed cycle still wins over the timeout.
          if (rdy_i) begin
            accept  = 1'b1;
            state_d = ACCUM;
          end else if (tout_q == 8'(TIMEOUT - 1)) begin
            timeout = 1'b1;
            state_d = ARM;
          end
        end
        ACCUM: begin
          avg_fire = (smp_q == SW'((1 << AVG_LOG2) - 1));
          state_d  = ARM;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q     <= '0;
      smp_q     <= '0;
      tout_q    <= '0;
      err_o     <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      if (start_o)                 tout_q <= 8'd1;
      else if (state_q == WAIT_RDY) tout_q <= tout_q + 8'd1;

      if (!en_i) begin
        acc_q     <= '0;
        smp_q     <= '0;
        err_o     <= 1'b0;
        overrun_o <= 1'b0;
      end else begin
        if (accept) acc_q <= acc_q + AW'(code_i);
        if (timeout) begin
          err_o <= 1'b1;
          acc_q <= '0;
          smp_q <= '0;
        end
        if (state_q == ACCUM) begin
          if (avg_fire) begin
            acc_q <= '0;
            smp_q <= '0;
          end else begin
            smp_q <= smp_q + SW'(1);
          end
        end
        if (avg_fire && valid_o && !ready_i) overrun_o <= 1'b1;
      end
    end
  end

  // Output register survives en_i=0; only a transfer or reset empties it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else if (avg_fire && (!valid_o || ready_i)) begin
      data_o  <= avg;
      valid_o <= 1'b1;
    end else if (xfer) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sar_sequencer.sv
// Directed bench for sar_sequencer with a SAR response model and a
// scoreboard that checks every downstream transfer.
module tb_sar_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, en, start, rdy, ready, valid, overrun, err;
  logic [7:0] code, data;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         xfers = 0;
  int         starts[$];
  logic [7:0] exp_q[$];
  logic [7:0] codes[$];
  bit         sar_on = 1'b0;
  int         cd = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sar_sequencer #(.RATE_DIV(16), .AVG_LOG2(2), .TIMEOUT(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .start_o(start), .rdy_i(rdy),
    .code_i(code), .data_o(data), .valid_o(valid), .ready_i(ready),
    .overrun_o(overrun), .err_o(err)
  );

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_starts(input int n, input int budget);
    int b = 0;
    while (starts.size() < n && b < budget) begin
      @(negedge clk);
      b++;
    end
    if (starts.size() < n) chk("wait_start_timeout", starts.size(), n);
  endtask

  task automatic wait_xfers(input int n, input int budget);
    int b = 0;
    while (xfers < n && b < budget) begin
      @(negedge clk);
      b++;
    end
    if (xfers < n) chk("wait_xfer_timeout", xfers, n);
  endtask

  task automatic wait_high(input string nm, input int sel, input int budget);
    int b = 0;
    while (((sel == 0) ? valid : overrun) !== 1'b1 && b < budget) begin
      @(negedge clk);
      b++;
    end
    if (b >= budget) chk(nm, 0, 1);
  endtask

  // SAR model: answers each start with the next queued code after 10 cycles.
  initial begin
    rdy  = 1'b0;
    code = '0;
    forever begin
      @(posedge clk);
      #2;
      rdy = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0 && codes.size() > 0) begin
          rdy  = 1'b1;
          code = codes.pop_front();
        end
      end
      if (start && sar_on) cd = 10;
    end
  end

  // Monitor: logs start pulses and scores every transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (start === 1'b1) starts.push_back(cyc);
      if (valid === 1'b1 && ready === 1'b1 && rst_n === 1'b1) begin
        xfers++;
        if (exp_q.size() == 0) chk("xfer_unexpected", int'(data), -1);
        else chk("xfer_data", int'(data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e, s, xb;
    rst_n = 1'b0;
    en    = 1'b0;
    ready = 1'b0;
    tick_n(2);
    chk("rst_start", start, 0);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    tick_n(2);

    // Basic average: (10+20+30+41)/4 = 25
    ready = 1'b1;
    sar_on = 1'b1;
    codes = '{8'd10, 8'd20, 8'd30, 8'd41};
    exp_q.push_back(8'd25);
    starts.delete();
    en = 1'b1;
    e = cyc;
    wait_starts(4, 100);
    if (starts.size() >= 4) begin
      chk("first_start_delay", starts[0] - e, 15);
      for (int i = 1; i < 4; i++) chk("start_period", starts[i] - starts[i-1], 16);
    end
    wait_xfers(1, 40);
    tick_n(2);
    chk("avg_valid_drop", valid, 0);
    chk("avg_overrun", overrun, 0);
    chk("avg_err", err, 0);
    chk("avg_xfer_count", xfers, 1);
    en = 1'b0;
    tick_n(3);

    // Full-scale codes must not overflow the accumulator
    codes = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    exp_q.push_back(8'hFF);
    en = 1'b1;
    wait_xfers(2, 120);
    tick_n(2);
    en = 1'b0;
    tick_n(3);

    // Back-pressure: second average (8) is lost, first (4) is held
    ready = 1'b0;
    codes = '{8'd4, 8'd4, 8'd4, 8'd4, 8'd8, 8'd8, 8'd8, 8'd8};
    exp_q.push_back(8'd4);
    en = 1'b1;
    wait_high("wait_overrun_timeout", 1, 200);
    chk("ovr_data_held", data, 4);
    chk("ovr_valid", valid, 1);
    chk("ovr_flag", overrun, 1);
    tick_n(1);
    en = 1'b0;
    tick_n(1);
    chk("dis_overrun_clr", overrun, 0);
    chk("dis_valid_kept", valid, 1);
    chk("dis_data_kept", data, 4);
    xb = xfers;
    ready = 1'b1;
    wait_xfers(xb + 1, 5);
    @(negedge clk);
    chk("post_xfer_valid", valid, 0);
    chk("single_xfer", xfers, xb + 1);
    tick_n(2);

    // Timeout: no rdy_i ever returned
    sar_on = 1'b0;
    codes.delete();
    starts.delete();
    en = 1'b1;
    wait_starts(1, 30);
    s = (starts.size() > 0) ? starts[0] : cyc;
    while (cyc < s + 31) @(negedge clk);
    chk("tout_err_early", err, 0);
    @(negedge clk);
    chk("tout_err_set", err, 1);
    chk("tout_restart", start, 1);
    chk("tout_no_valid", valid, 0);
    tick_n(1);
    en = 1'b0;
    tick_n(1);
    chk("tout_err_clr", err, 0);
    tick_n(2);

    // Disable mid-conversion; the late rdy_i (code 0x77) must be ignored
    sar_on = 1'b1;
    codes = '{8'h77};
    starts.delete();
    en = 1'b1;
    wait_starts(1, 30);
    tick_n(4);
    en = 1'b0;
    tick_n(20);
    chk("dis_no_start", starts.size(), 1);
    chk("dis_err", err, 0);
    chk("dis_overrun", overrun, 0);
    chk("dis_no_valid", valid, 0);
    codes = '{8'd1, 8'd2, 8'd3, 8'd6};
    exp_q.push_back(8'd3);
    starts.delete();
    xb = xfers;
    en = 1'b1;
    e = cyc;
    wait_starts(1, 30);
    if (starts.size() > 0) chk("reen_first_start", starts[0] - e, 15);
    wait_xfers(xb + 1, 80);
    tick_n(2);
    en = 1'b0;
    tick_n(3);

    // Asynchronous reset while an average is pending
    ready = 1'b0;
    codes = '{8'd40, 8'd40, 8'd40, 8'd40};
    en = 1'b1;
    wait_high("wait_valid_timeout", 0, 120);
    chk("pre_rst_valid", valid, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", valid, 0);
    chk("async_rst_data", data, 0);
    chk("async_rst_start", start, 0);
    en = 1'b0;
    tick_n(2);
    rst_n = 1'b1;
    tick_n(2);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
